// File: rtl/memory_to_pixel_stream256.sv
// Sequential pixel unpacker: takes one 256-bit memory line plus a start bit offset and
// pixel count, then streams the packed pixels LSB-first one per cycle under valid/ready.
module memory_to_pixel_stream256 #(
  parameter bit BPP12 = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   color_depth_i,
  input  logic         line_valid_i,
  output logic         line_ready_o,
  input  logic [255:0] line_i,
  input  logic [7:0]   mb_i,
  input  logic [5:0]   count_i,
  output logic         pix_valid_o,
  input  logic         pix_ready_i,
  output logic [31:0]  pix_o,
  output logic [7:0]   pix_mb_o,
  output logic         pix_last_o,
  output logic         done_o,
  output logic         trunc_o,
  output logic         busy_o
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t         state_q, state_d;
  logic [255:0]   line_q;
  logic [1:0]     depth_q;
  logic [7:0]     mb_q;
  logic [5:0]     rem_q;
  logic           done_q, done_d;
  logic           trunc_q, trunc_d;

  logic [8:0]     w_in;
  logic [8:0]     w_q;
  logic [31:0]    mask_q;
  logic [31:0]    window;
  logic           bad_desc;
  logic           last;

  // Pixel width equals stride for every depth; 12bpp replaces 16bpp when BPP12 is set.
  function automatic logic [8:0] depth_width(input logic [1:0] d);
    case (d)
      2'b00:   depth_width = 9'd8;
      2'b01:   depth_width = BPP12 ? 9'd12 : 9'd16;
      2'b10:   depth_width = 9'd24;
      default: depth_width = 9'd32;
    endcase
  endfunction

  function automatic logic [31:0] depth_mask(input logic [1:0] d);
    case (d)
      2'b00:   depth_mask = 32'h0000_00FF;
      2'b01:   depth_mask = BPP12 ? 32'h0000_0FFF : 32'h0000_FFFF;
      2'b10:   depth_mask = 32'h00FF_FFFF;
      default: depth_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  assign w_in     = depth_width(color_depth_i);
  assign w_q      = depth_width(depth_q);
  assign mask_q   = depth_mask(depth_q);
  assign window   = 32'(line_q >> mb_q);
  assign bad_desc = (count_i == 6'd0) || (({1'b0, mb_i} + w_in) > 9'd256);
  // Last when the count runs out or the following pixel would not fit in the line.
  assign last     = (rem_q == 6'd1) ||
                    ((10'(mb_q) + 10'(w_q) + 10'(w_q)) > 10'd256);

  assign line_ready_o = (state_q == IDLE) && !rst_i;
  assign pix_valid_o  = (state_q == EMIT);
  assign busy_o       = (state_q != IDLE);
  assign pix_o        = (state_q == EMIT) ? (window & mask_q) : 32'd0;
  assign pix_mb_o     = (state_q == EMIT) ? mb_q : 8'd0;
  assign pix_last_o   = (state_q == EMIT) && last;
  assign done_o       = done_q;
  assign trunc_o      = trunc_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    trunc_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_valid_i) begin
          if (bad_desc) begin
            done_d  = 1'b1;
            trunc_d = (count_i != 6'd0);
          end else begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (pix_ready_i && last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          trunc_d = (rem_q > 6'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Descriptor is captured only on the accept handshake; the pointer advances per handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
      line_q  <= '0;
      depth_q <= 2'b00;
      mb_q    <= 8'd0;
      rem_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      trunc_q <= trunc_d;
      if (state_q == IDLE && line_valid_i) begin
        line_q  <= line_i;
        depth_q <= color_depth_i;
        mb_q    <= mb_i;
        rem_q   <= count_i;
      end else if (state_q == EMIT && pix_ready_i && !last) begin
        mb_q  <= mb_q + w_q[7:0];
        rem_q <= rem_q - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_memory_to_pixel_stream256.sv
// Directed self-checking bench for memory_to_pixel_stream256; a second instance covers 12bpp.
module tb_memory_to_pixel_stream256;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [1:0]   color_depth_i = 2'b00;
  logic         line_valid_i = 1'b0;
  logic [255:0] line_i = '0;
  logic [7:0]   mb_i = 8'd0;
  logic [5:0]   count_i = 6'd0;
  logic         pix_ready_i = 1'b1;

  logic         lr0, pv0, pl0, dn0, tr0, bz0;
  logic [31:0]  px0;
  logic [7:0]   pm0;
  logic         lr1, pv1, pl1, dn1, tr1, bz1;
  logic [31:0]  px1;
  logic [7:0]   pm1;

  logic         sel = 1'b0;
  logic         line_ready, pix_valid, pix_last, done, trunc, busy;
  logic [31:0]  pix;
  logic [7:0]   pix_mb;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0]  expPix [64];
  logic [7:0]   expMb [64];
  int           expN;
  logic         expTrunc;
  bit           rdyPat [$];
  logic [255:0] lineA, lineB, lineOnes;

  memory_to_pixel_stream256 #(.BPP12(1'b0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .color_depth_i(color_depth_i),
    .line_valid_i(line_valid_i), .line_ready_o(lr0), .line_i(line_i),
    .mb_i(mb_i), .count_i(count_i), .pix_valid_o(pv0), .pix_ready_i(pix_ready_i),
    .pix_o(px0), .pix_mb_o(pm0), .pix_last_o(pl0), .done_o(dn0),
    .trunc_o(tr0), .busy_o(bz0)
  );

  memory_to_pixel_stream256 #(.BPP12(1'b1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .color_depth_i(color_depth_i),
    .line_valid_i(line_valid_i), .line_ready_o(lr1), .line_i(line_i),
    .mb_i(mb_i), .count_i(count_i), .pix_valid_o(pv1), .pix_ready_i(pix_ready_i),
    .pix_o(px1), .pix_mb_o(pm1), .pix_last_o(pl1), .done_o(dn1),
    .trunc_o(tr1), .busy_o(bz1)
  );

  assign line_ready = sel ? lr1 : lr0;
  assign pix_valid  = sel ? pv1 : pv0;
  assign pix_last   = sel ? pl1 : pl0;
  assign done       = sel ? dn1 : dn0;
  assign trunc      = sel ? tr1 : tr0;
  assign busy       = sel ? bz1 : bz0;
  assign pix        = sel ? px1 : px0;
  assign pix_mb     = sel ? pm1 : pm0;

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one line descriptor at a negedge and returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [1:0] depth, input logic [255:0] line,
                               input logic [7:0] mb, input logic [5:0] count);
    int waited = 0;
    while (!line_ready && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    if (!line_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
    color_depth_i = depth;
    line_i        = line;
    mb_i          = mb;
    count_i       = count;
    line_valid_i  = 1'b1;
    @(negedge clk_i);
    line_valid_i  = 1'b0;
    line_i        = {8{$urandom}};
    mb_i          = 8'($urandom);
    count_i       = 6'($urandom);
    color_depth_i = 2'($urandom);
  endtask

  task automatic collectLine(input string tag, input int budget);
    int idx = 0;
    int stalls = 0;
    int cyc = 0;
    bit seen = 0;
    bit rdy;
    while (!seen && cyc < budget) begin
      rdy = (rdyPat.size() != 0) ? rdyPat.pop_front() : 1'b1;
      pix_ready_i = rdy;
      if (done) begin
        seen = 1;
        checkOutput($sformatf("%s_done_cycle", tag), 64'(cyc), 64'(expN + stalls));
        checkOutput($sformatf("%s_trunc", tag), 64'(trunc), 64'(expTrunc));
      end else if (pix_valid) begin
        if (idx < expN) begin
          checkOutput($sformatf("%s_pix%0d", tag, idx), 64'(pix), 64'(expPix[idx]));
          checkOutput($sformatf("%s_mb%0d", tag, idx), 64'(pix_mb), 64'(expMb[idx]));
          checkOutput($sformatf("%s_last%0d", tag, idx), 64'(pix_last),
                      64'(idx == expN - 1));
        end else begin
          checkOutput($sformatf("%s_extra_pixel", tag), 64'(idx), 64'(expN));
        end
        if (rdy) idx++;
        else stalls++;
      end
      @(negedge clk_i);
      cyc++;
    end
    if (!seen) checkOutput($sformatf("%s_done_timeout", tag), 64'd0, 64'd1);
    checkOutput($sformatf("%s_count", tag), 64'(idx), 64'(expN));
    pix_ready_i = 1'b1;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      lineA[8*k +: 8] = 8'(k);
      lineB[8*k +: 8] = 8'(8'hA0 + k);
    end
    lineOnes = '1;

    repeat (2) @(negedge clk_i);
    checkOutput("rst_line_ready", 64'(line_ready), 64'd0);
    checkOutput("rst_pix_valid", 64'(pix_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_trunc", 64'(trunc), 64'd0);
    checkOutput("rst_last", 64'(pix_last), 64'd0);
    checkOutput("rst_pix", 64'(pix), 64'd0);
    checkOutput("rst_pix_mb", 64'(pix_mb), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idle_line_ready", 64'(line_ready), 64'd1);

    // 8bpp full line
    for (int k = 0; k < 32; k++) begin
      expPix[k] = 32'(k);
      expMb[k]  = 8'(8 * k);
    end
    expN = 32; expTrunc = 1'b0;
    applyStimulus(2'b00, lineA, 8'd0, 6'd32);
    collectLine("t1_8bpp", 100);

    // 32bpp at the top of the line
    expPix[0] = 32'h1F1E1D1C; expMb[0] = 8'd224;
    expN = 1; expTrunc = 1'b1;
    applyStimulus(2'b11, lineA, 8'd224, 6'd4);
    collectLine("t2_32bpp", 20);

    // 16bpp with stalls
    expPix[0] = 32'h0302; expMb[0] = 8'd16;
    expPix[1] = 32'h0504; expMb[1] = 8'd32;
    expPix[2] = 32'h0706; expMb[2] = 8'd48;
    expN = 3; expTrunc = 1'b0;
    rdyPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    applyStimulus(2'b01, lineA, 8'd16, 6'd3);
    collectLine("t3_16bpp_stall", 30);

    // 12bpp on the BPP12 instance, then 24bpp truncated
    sel = 1'b1;
    doReset();
    for (int k = 0; k < 21; k++) begin
      expPix[k] = 32'hFFF;
      expMb[k]  = 8'(12 * k);
    end
    expN = 21; expTrunc = 1'b0;
    applyStimulus(2'b01, lineOnes, 8'd0, 6'd21);
    collectLine("t4_12bpp", 60);
    for (int k = 0; k < 10; k++) begin
      expPix[k] = 32'hFFFFFF;
      expMb[k]  = 8'(24 * k);
    end
    expN = 10; expTrunc = 1'b1;
    applyStimulus(2'b10, lineOnes, 8'd0, 6'd11);
    collectLine("t4_24bpp", 40);
    sel = 1'b0;
    doReset();

    // Degenerate descriptors
    expN = 0; expTrunc = 1'b0;
    applyStimulus(2'b00, lineA, 8'd0, 6'd0);
    collectLine("t5_count0", 10);
    expN = 0; expTrunc = 1'b1;
    applyStimulus(2'b01, lineA, 8'd250, 6'd1);
    collectLine("t5_overflow", 10);

    // Reset in the middle of a line
    applyStimulus(2'b00, lineB, 8'd0, 6'd8);
    checkOutput("t6_first_pix", 64'(pix), 64'hA0);
    repeat (2) @(negedge clk_i);
    checkOutput("t6_third_pix", 64'(pix), 64'hA2);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("t6_rst_valid", 64'(pix_valid), 64'd0);
    checkOutput("t6_rst_done", 64'(done), 64'd0);
    checkOutput("t6_rst_busy", 64'(busy), 64'd0);
    checkOutput("t6_rst_line_ready", 64'(line_ready), 64'd0);
    checkOutput("t6_rst_pix", 64'(pix), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t6_post_done", 64'(done), 64'd0);
    checkOutput("t6_post_ready", 64'(line_ready), 64'd1);
    expPix[0] = 32'h05; expMb[0] = 8'd40;
    expPix[1] = 32'h06; expMb[1] = 8'd48;
    expPix[2] = 32'h07; expMb[2] = 8'd56;
    expN = 3; expTrunc = 1'b0;
    applyStimulus(2'b00, lineA, 8'd40, 6'd3);
    collectLine("t6_after_reset", 20);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
